// File: rtl/irrig_pkg.sv
// Shared definitions for the irrigation tank blocks.
//   LEVEL_W / LEVEL_MAX : width and top value of the tank level
//   *_TH_DEF            : default sensor thresholds (l, m, h)
//   dir_state_t         : flow-direction state (HOLD, FILLING, DRAINING)
//   thermo()            : {h,m,l} thermometer decode of a level
package irrig_pkg;

  localparam int unsigned LEVEL_W   = 4;
  localparam int unsigned LEVEL_MAX = 15;

  localparam int unsigned L_TH_DEF = 4;
  localparam int unsigned M_TH_DEF = 8;
  localparam int unsigned H_TH_DEF = 12;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    FILLING  = 2'd1,
    DRAINING = 2'd2
  } dir_state_t;

  // Returns {h,m,l}. Because l_th < m_th < h_th, the result can only be
  // 000, 001, 011 or 111.
  function automatic logic [2:0] thermo(
    input logic [LEVEL_W-1:0] lvl,
    input logic [LEVEL_W-1:0] l_th,
    input logic [LEVEL_W-1:0] m_th,
    input logic [LEVEL_W-1:0] h_th
  );
    thermo = {(lvl >= h_th), (lvl >= m_th), (lvl >= l_th)};
  endfunction

endpackage

// File: rtl/step_timer.sv
// Prescaler that paces level changes.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   run   : count while high; held at 0 while low
//   clear : restart the count from 0 (used on a direction change)
//   tick  : high during the last cycle of each STEP_DIV-cycle period
module step_timer #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  logic [7:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/tank_level_encoder.sv
// Tank level model with thermometer-coded level sensors.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   fill_en  : inlet valve open (level rises)
//   drain_en : outlet valve open (level falls)
//   level    : current level 0..15
//   h, m, l  : level >= H_TH / M_TH / L_TH
//   full     : level == 15
//   empty    : level == 0
//   step     : one-cycle pulse on the edge where level changed
// All outputs are registered and decoded from the next level so they move
// together on the same edge.
module tank_level_encoder
  import irrig_pkg::*;
#(
  parameter int unsigned STEP_DIV = 4,
  parameter int unsigned L_TH     = L_TH_DEF,
  parameter int unsigned M_TH     = M_TH_DEF,
  parameter int unsigned H_TH     = H_TH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fill_en,
  input  logic               drain_en,
  output logic [LEVEL_W-1:0] level,
  output logic               h,
  output logic               m,
  output logic               l,
  output logic               full,
  output logic               empty,
  output logic               step
);

  localparam logic [LEVEL_W-1:0] L_TH_V = LEVEL_W'(L_TH);
  localparam logic [LEVEL_W-1:0] M_TH_V = LEVEL_W'(M_TH);
  localparam logic [LEVEL_W-1:0] H_TH_V = LEVEL_W'(H_TH);
  localparam logic [LEVEL_W-1:0] TOP    = LEVEL_W'(LEVEL_MAX);

  dir_state_t         state, state_next;
  logic               run, clear, tick;
  logic [LEVEL_W-1:0] level_next;
  logic               step_next;
  logic [2:0]         sens_next;

  // Direction state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
    end else begin
      state <= state_next;
    end
  end

  // Both valves open means no net flow, so that case falls to HOLD.
  always_comb begin
    state_next = HOLD;
    if (fill_en && !drain_en) begin
      state_next = FILLING;
    end else if (drain_en && !fill_en) begin
      state_next = DRAINING;
    end
  end

  assign run   = (state != HOLD);
  // Restarting on every change makes the first step after a direction
  // change land exactly STEP_DIV cycles after the new state is entered.
  assign clear = (state_next != state);

  step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .clear (clear),
    .tick  (tick)
  );

  // Level update; saturates at both ends without touching the prescaler.
  always_comb begin
    level_next = level;
    step_next  = 1'b0;
    if (tick) begin
      if (state == FILLING && level != TOP) begin
        level_next = level + 1'b1;
        step_next  = 1'b1;
      end else if (state == DRAINING && level != '0) begin
        level_next = level - 1'b1;
        step_next  = 1'b1;
      end
    end
  end

  assign sens_next = thermo(level_next, L_TH_V, M_TH_V, H_TH_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      h     <= 1'b0;
      m     <= 1'b0;
      l     <= 1'b0;
      full  <= 1'b0;
      empty <= 1'b1;
      step  <= 1'b0;
    end else begin
      level <= level_next;
      h     <= sens_next[2];
      m     <= sens_next[1];
      l     <= sens_next[0];
      full  <= (level_next == TOP);
      empty <= (level_next == '0);
      step  <= step_next;
    end
  end

endmodule

// File: tb/tb_tank_level_encoder.sv
// Directed bench for tank_level_encoder (STEP_DIV=4, thresholds 4/8/12).
// Cycle k counts rising edges after the edge on which the new direction
// state is entered; outputs are sampled 1 time unit after each edge.
module tb_tank_level_encoder;

  logic       clk;
  logic       rst_n;
  logic       fill_en;
  logic       drain_en;
  logic [3:0] level;
  logic       h, m, l, full, empty, step;

  int tests;
  int fails;

  tank_level_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fill_en  (fill_en),
    .drain_en (drain_en),
    .level    (level),
    .h        (h),
    .m        (m),
    .l        (l),
    .full     (full),
    .empty    (empty),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] hml_of(input int lvl);
    hml_of = {(lvl >= 12), (lvl >= 8), (lvl >= 4)};
  endfunction

  initial begin
    int exp_lvl;
    int prev;
    logic ok;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    fill_en = 1'b0;
    drain_en = 1'b0;

    // ---- reset state
    cyc(3);
    check("rst_level", 32'(level), 32'd0);
    check("rst_hml", 32'({h, m, l}), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_step", 32'(step), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    check("idle_level", 32'(level), 32'd0);

    // ---- fill from 0: steps every 4 cycles, saturate at 15 (cycle 60)
    fill_en = 1'b1;
    cyc(1); // entry edge
    for (int k = 1; k <= 70; k++) begin
      cyc(1);
      exp_lvl = (k / 4 > 15) ? 15 : k / 4;
      check($sformatf("fill_lvl_k%0d", k), 32'(level), 32'(exp_lvl));
      check($sformatf("fill_step_k%0d", k), 32'(step), 32'((k % 4 == 0) && (k <= 60)));
      check($sformatf("fill_hml_k%0d", k), 32'({h, m, l}), 32'(hml_of(exp_lvl)));
      check($sformatf("fill_full_k%0d", k), 32'(full), 32'(exp_lvl == 15));
    end
    fill_en = 1'b0;

    // ---- drain 15 -> 9
    cyc(2);
    drain_en = 1'b1;
    cyc(1);
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      check($sformatf("drn_lvl_k%0d", k), 32'(level), 32'(15 - k / 4));
    end
    drain_en = 1'b0;
    cyc(3);
    check("hold9_level", 32'(level), 32'd9);

    // ---- drain from 9: 8 at k=4 (m=1), 7 at k=8 (m=0), floor at 0
    drain_en = 1'b1;
    cyc(1);
    for (int k = 1; k <= 50; k++) begin
      cyc(1);
      exp_lvl = (9 - k / 4 < 0) ? 0 : 9 - k / 4;
      check($sformatf("d9_lvl_k%0d", k), 32'(level), 32'(exp_lvl));
      check($sformatf("d9_m_k%0d", k), 32'(m), 32'(exp_lvl >= 8));
      check($sformatf("d9_step_k%0d", k), 32'(step), 32'((k % 4 == 0) && (k <= 36)));
      check($sformatf("d9_empty_k%0d", k), 32'(empty), 32'(exp_lvl == 0));
    end
    drain_en = 1'b0;
    cyc(2);

    // ---- fill to 5
    fill_en = 1'b1;
    cyc(1);
    cyc(20);
    check("to5_level", 32'(level), 32'd5);

    // ---- both valves: net zero, level holds
    drain_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      check($sformatf("both_lvl_k%0d", k), 32'(level), 32'd5);
      check($sformatf("both_step_k%0d", k), 32'(step), 32'd0);
    end
    // short fill then short drain: prescaler restarts each time
    drain_en = 1'b0;
    fill_en = 1'b1;
    cyc(3);
    check("short_fill_lvl", 32'(level), 32'd5);
    fill_en = 1'b0;
    drain_en = 1'b1;
    cyc(3);
    check("short_drain_lvl", 32'(level), 32'd5);
    drain_en = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      check($sformatf("after_short_lvl_k%0d", k), 32'(level), 32'd5);
      check($sformatf("after_short_step_k%0d", k), 32'(step), 32'd0);
    end

    // ---- fill to 10, reset mid-count
    fill_en = 1'b1;
    cyc(1);
    cyc(20);
    check("to10_level", 32'(level), 32'd10);
    check("to10_hml", 32'({h, m, l}), 32'b011);
    cyc(2); // prescaler part-way
    rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_hml", 32'({h, m, l}), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_step", 32'(step), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1); // entry edge into FILLING
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check($sformatf("post_rst_lvl_k%0d", k), 32'(level), 32'(k == 4));
      check($sformatf("post_rst_step_k%0d", k), 32'(step), 32'(k == 4));
    end
    fill_en = 1'b0;

    // ---- randomised invariants
    prev = int'(level);
    for (int k = 0; k < 10000; k++) begin
      fill_en = 1'($urandom_range(0, 1));
      drain_en = 1'($urandom_range(0, 1));
      cyc(1);
      ok = 1'b1;
      if (!({h, m, l} inside {3'b000, 3'b001, 3'b011, 3'b111})) ok = 1'b0;
      if ({h, m, l} != hml_of(int'(level))) ok = 1'b0;
      if (int'(level) - prev > 1 || prev - int'(level) > 1) ok = 1'b0;
      if (step != (int'(level) != prev)) ok = 1'b0;
      if (full != (level == 4'd15) || empty != (level == 4'd0)) ok = 1'b0;
      check($sformatf("rand_inv_k%0d_lvl%0d_prev%0d", k, level, prev), 32'(ok), 32'd1);
      prev = int'(level);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
